branch_resolve_unit: RTL

- Consumes the ALU's SUB result flags (defs::t_flag) and resolves conditional branches.
- Stage 1 registers the flags, condition and PC operands. Stage 2 evaluates the condition and computes the target and fall-through PCs.
- Valid/ready handshake on both sides, synchronous flush, and saturating branch statistics counters.
- Sits between the ALU flag output and the fetch-redirect logic.

---
 rtl/branch_resolve_unit_pkg.sv | 25 ++
 rtl/branch_resolve_unit_cond_eval.sv | 39 +++
 rtl/branch_resolve_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve path.
//   t_flag    : ALU SUB flags; carryOut=1 means a borrow occurred (rs1 < rs2 unsigned)
//   t_brcond  : branch condition in funct3 encoding (010/011 are reserved)
//   PC_INC    : fall-through increment
package defs;

  typedef struct packed {
    logic zero;
    logic sign;
    logic overflow;
    logic carryOut;
  } t_flag;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } t_brcond;

  localparam int PC_INC = 4;

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// br_cond_eval: combinational branch condition evaluator.
// Ports:
//   i_flag    in  t_flag     SUB flags of rs1-rs2
//   i_cond    in  [2:0]      funct3 condition
//   o_taken   out            condition holds
//   o_illegal out            reserved encoding (never taken)
module br_cond_eval
  import defs::*;
(
  input  t_flag      i_flag,
  input  logic [2:0] i_cond,
  output logic       o_taken,
  output logic       o_illegal
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = i_flag.zero;
  // Signed less-than survives overflow: the sign is wrong exactly when overflow is set.
  assign w_lt  = i_flag.sign ^ i_flag.overflow;
  assign w_ltu = i_flag.carryOut;

  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    case (i_cond)
      BEQ:     o_taken = w_eq;
      BNE:     o_taken = ~w_eq;
      BLT:     o_taken = w_lt;
      BGE:     o_taken = ~w_lt;
      BLTU:    o_taken = w_ltu;
      BGEU:    o_taken = ~w_ltu;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: two-stage conditional branch resolver.
// Stage 1 captures flags/condition/PC operands; stage 2 holds the resolved
// result (taken, target, fall-through, illegal). Valid/ready on both sides.
// Ports:
//   iClk, iRst            clock, synchronous active-high reset
//   iValid/oReady         input handshake
//   iFlag, iCond          ALU SUB flags and funct3 condition
//   iPC, iOffset          branch PC and sign-extended offset
//   iFlush                drop all in-flight entries
//   oValid/iReady         output handshake
//   oTaken, oTarget, oNextPC, oIllegal   resolved result
//   oBrCnt, oTakenCnt     saturating statistics counters
module branch_resolve_unit
  import defs::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  t_flag            iFlag,
  input  logic [2:0]       iCond,
  input  logic [N-1:0]     iPC,
  input  logic [N-1:0]     iOffset,
  input  logic             iFlush,
  output logic             oValid,
  input  logic             iReady,
  output logic             oTaken,
  output logic [N-1:0]     oTarget,
  output logic [N-1:0]     oNextPC,
  output logic             oIllegal,
  output logic [CNT_W-1:0] oBrCnt,
  output logic [CNT_W-1:0] oTakenCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_s1_valid;
  t_flag            r_s1_flag;
  logic [2:0]       r_s1_cond;
  logic [N-1:0]     r_s1_pc;
  logic [N-1:0]     r_s1_off;

  logic             r_s2_valid;
  logic             r_taken;
  logic [N-1:0]     r_target;
  logic [N-1:0]     r_nextpc;
  logic             r_illegal;

  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic             w_s1_adv;
  logic             w_accept;
  logic             w_out_hs;
  logic             w_taken;
  logic             w_illegal;

  assign w_s1_adv = ~r_s2_valid | iReady;
  assign oReady   = ~r_s1_valid | w_s1_adv;
  assign w_accept = iValid & oReady;
  assign w_out_hs = r_s2_valid & iReady;

  br_cond_eval u_cond_eval (
    .i_flag    (r_s1_flag),
    .i_cond    (r_s1_cond),
    .o_taken   (w_taken),
    .o_illegal (w_illegal)
  );

  // Valid bits: reset, then flush, then normal advance.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (iFlush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) r_s2_valid <= r_s1_valid;
      if (oReady)   r_s1_valid <= iValid;
    end
  end

  // Stage 1 data is don't-care while invalid, so it is not reset.
  always_ff @(posedge iClk) begin
    if (!iRst && !iFlush && w_accept) begin
      r_s1_flag <= iFlag;
      r_s1_cond <= iCond;
      r_s1_pc   <= iPC;
      r_s1_off  <= iOffset;
    end
  end

  // Stage 2 results only load when a valid entry moves in, so they hold under backpressure.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_taken   <= 1'b0;
      r_target  <= '0;
      r_nextpc  <= '0;
      r_illegal <= 1'b0;
    end else if (!iFlush && w_s1_adv && r_s1_valid) begin
      r_taken   <= w_taken;
      r_target  <= r_s1_pc + r_s1_off;
      r_nextpc  <= r_s1_pc + N'(PC_INC);
      r_illegal <= w_illegal;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else if (!iFlush && w_out_hs) begin
      if (r_br_cnt != CNT_MAX) r_br_cnt <= r_br_cnt + 1'b1;
      if (r_taken && (r_taken_cnt != CNT_MAX)) r_taken_cnt <= r_taken_cnt + 1'b1;
    end
  end

  assign oValid    = r_s2_valid;
  assign oTaken    = r_taken;
  assign oTarget   = r_target;
  assign oNextPC   = r_nextpc;
  assign oIllegal  = r_illegal;
  assign oBrCnt    = r_br_cnt;
  assign oTakenCnt = r_taken_cnt;

endmodule
